// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle control sequencer.
//   state_e        - sequencer FSM states
//   OP_*           - opcode values (IR[31:26])
//   *_HI / *_LO    - instruction-register field boundaries
//   sext_imm()     - sign-extends the 21-bit LI immediate to 32 bits
package mc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt,
    StFault
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LI    = 6'h01;
  localparam logic [5:0] OP_NOP   = 6'h3E;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned WA_HI  = 25;
  localparam int unsigned WA_LO  = 21;
  localparam int unsigned RA1_HI = 20;
  localparam int unsigned RA1_LO = 16;
  localparam int unsigned RA2_HI = 15;
  localparam int unsigned RA2_LO = 11;
  localparam int unsigned SFT_HI = 10;
  localparam int unsigned SFT_LO = 6;
  localparam int unsigned CON_HI = 2;
  localparam int unsigned CON_LO = 0;
  localparam int unsigned IMM_HI = 20;
  localparam int unsigned IMM_LO = 0;

  function automatic logic [31:0] sext_imm(input logic [IMM_HI:IMM_LO] imm);
    return {{(31 - IMM_HI){imm[IMM_HI]}}, imm};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction decoder.
//   ir_i        - instruction register
//   is_rtype_o  - R-type ALU instruction (writes ALU result)
//   is_li_o     - load-immediate (writes sign-extended immediate)
//   is_halt_o   - HALT
//   illegal_o   - opcode not R-type, LI, NOP or HALT
//   alu_con_o   - ALU operation (IR[2:0] for R-type, else 0)
//   alu_sft_o   - shift amount (IR[10:6] for R-type, else 0)
//   imm_o       - sign-extended immediate
//   wa_o / ra1_o / ra2_o - register-file address fields
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        is_rtype_o,
  output logic        is_li_o,
  output logic        is_halt_o,
  output logic        illegal_o,
  output logic [2:0]  alu_con_o,
  output logic [4:0]  alu_sft_o,
  output logic [31:0] imm_o,
  output logic [4:0]  wa_o,
  output logic [4:0]  ra1_o,
  output logic [4:0]  ra2_o
);

  logic [5:0] opcode;
  logic       is_nop;

  always_comb begin
    opcode     = ir_i[OP_HI:OP_LO];
    is_rtype_o = (opcode == OP_RTYPE);
    is_li_o    = (opcode == OP_LI);
    is_nop     = (opcode == OP_NOP);
    is_halt_o  = (opcode == OP_HALT);
    illegal_o  = !(is_rtype_o || is_li_o || is_nop || is_halt_o);
    alu_con_o  = is_rtype_o ? ir_i[CON_HI:CON_LO] : 3'd0;
    alu_sft_o  = is_rtype_o ? ir_i[SFT_HI:SFT_LO] : 5'd0;
    imm_o      = sext_imm(ir_i[IMM_HI:IMM_LO]);
    wa_o       = ir_i[WA_HI:WA_LO];
    ra1_o      = ir_i[RA1_HI:RA1_LO];
    ra2_o      = ir_i[RA2_HI:RA2_LO];
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle fetch/decode/execute/write-back control sequencer.
//   clk, rst (async, active-low)
//   start                      - leaves IDLE or HALT
//   imem_req/addr/ack/rdata    - instruction fetch handshake
//   rf_ra1/ra2/wa/we/wd        - register-file control, one write per writing instruction
//   alu_con/alu_sft, alu_res   - ALU control and result
//   busy/halted/fault/retired  - status
// Every output is decoded from state or registered values; no input reaches an output
// combinationally.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned PC_W        = 5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  output logic [4:0]      rf_wa,
  output logic            rf_we,
  output logic [31:0]     rf_wd,
  output logic [2:0]      alu_con,
  output logic [4:0]      alu_sft,
  input  logic [31:0]     alu_res,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [15:0]     retired
);

  localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       res_q, res_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [WaitW-1:0]  wait_inc;
  logic [15:0]       retired_q, retired_d;

  logic        dec_rtype, dec_li, dec_halt, dec_illegal;
  logic [2:0]  dec_con;
  logic [4:0]  dec_sft;
  logic [31:0] dec_imm;

  mc_decode u_decode (
    .ir_i       (ir_q),
    .is_rtype_o (dec_rtype),
    .is_li_o    (dec_li),
    .is_halt_o  (dec_halt),
    .illegal_o  (dec_illegal),
    .alu_con_o  (dec_con),
    .alu_sft_o  (dec_sft),
    .imm_o      (dec_imm),
    .wa_o       (rf_wa),
    .ra1_o      (rf_ra1),
    .ra2_o      (rf_ra2)
  );

  assign wait_inc = wait_q + WaitW'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    res_d     = res_q;
    wait_d    = wait_q;
    retired_d = retired_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wait_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // An ack in the cycle the counter would hit the limit still wins.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = StDecode;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WaitW'(ACK_TIMEOUT)) begin
            state_d = StFault;
          end
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          state_d = StFault;
        end else if (dec_halt) begin
          // HALT retires here; the PC advances only when the core is restarted.
          retired_d = retired_q + 16'd1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_rtype) begin
          res_d = alu_res;
        end else if (dec_li) begin
          res_d = dec_imm;
        end
        state_d = StWb;
      end
      StWb: begin
        pc_d      = pc_q + PC_W'(4);
        retired_d = retired_q + 16'd1;
        wait_d    = '0;
        state_d   = StFetch;
      end
      StHalt: begin
        if (start) begin
          pc_d    = pc_q + PC_W'(4);
          wait_d  = '0;
          state_d = StFetch;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      res_q     <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    imem_req  = (state_q == StFetch);
    imem_addr = pc_q;
    rf_we     = (state_q == StWb) && (dec_rtype || dec_li);
    rf_wd     = res_q;
    alu_con   = (state_q == StExec) ? dec_con : 3'd0;
    alu_sft   = (state_q == StExec) ? dec_sft : 5'd0;
    busy      = !(state_q inside {StIdle, StHalt, StFault});
    halted    = (state_q == StHalt);
    fault     = (state_q == StFault);
    retired   = retired_q;
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed bench for mc_sequencer. An instruction-level model predicts each
// register write (address, data, cycle) and the fetch address; a per-cycle compare process
// checks the DUT against it, and directed steps pin the model with hand-computed literals.
module tb_mc_sequencer;

  logic        clk, rst, start;
  logic        imem_req, imem_ack;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa, alu_sft;
  logic        rf_we, busy, halted, fault;
  logic [31:0] rf_wd, alu_res;
  logic [2:0]  alu_con;
  logic [15:0] retired;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned start_cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t         exp_q[$];
  logic [4:0]  model_pc;
  logic [15:0] model_ret;
  bit          model_halted;

  localparam logic [31:0] InsNop  = {6'h3E, 26'h0};
  localparam logic [31:0] InsHalt = {6'h3F, 26'h0};
  localparam logic [31:0] InsIll  = {6'h05, 26'h0};

  // ALU stand-in: a recognisable function of the register addresses and ALU controls.
  function automatic logic [31:0] alu_fn(input logic [4:0] a, input logic [4:0] b,
                                         input logic [2:0] c, input logic [4:0] s);
    return {a, b, s, c, 14'h2A5};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] wa, input logic [4:0] ra1,
                                        input logic [4:0] ra2, input logic [4:0] sft,
                                        input logic [2:0] con);
    return {6'h00, wa, ra1, ra2, sft, 3'b000, con};
  endfunction

  function automatic logic [31:0] li(input logic [4:0] wa, input logic [20:0] imm);
    return {6'h01, wa, imm};
  endfunction

  assign alu_res = alu_fn(rf_ra1, rf_ra2, alu_con, alu_sft);

  mc_sequencer #(
    .PC_W        (5),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_wa      (rf_wa),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd),
    .alu_con    (alu_con),
    .alu_sft    (alu_sft),
    .alu_res    (alu_res),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    wr_t e;
    if (rst === 1'b1) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_we: rf_we=1 at cycle %0d (wa=%0d), expected no write",
                   cyc, rf_wa);
        end else begin
          e = exp_q.pop_front();
          chk("we_cycle", 32'(cyc), 32'(e.cyc));
          chk("rf_wa", 32'(rf_wa), 32'(e.wa));
          chk("rf_wd", rf_wd, e.wd);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_we: rf_we=0 at cycle %0d, expected write to %0d",
                 cyc, exp_q[0].wa);
        e = exp_q.pop_front();
      end
      if (imem_req === 1'b1) chk("imem_addr", 32'(imem_addr), 32'(model_pc));
    end
  end

  // Instruction-level effect of an accepted fetch.
  task automatic model_apply(input logic [31:0] w, input int unsigned ack_cyc);
    wr_t e;
    logic [5:0] op;
    op = w[31:26];
    e.cyc = ack_cyc + 3;
    e.wa  = w[25:21];
    case (op)
      6'h00: begin
        e.wd = alu_fn(w[20:16], w[15:11], w[2:0], w[10:6]);
        exp_q.push_back(e);
        model_pc = model_pc + 5'd4;
        model_ret++;
      end
      6'h01: begin
        e.wd = {{11{w[20]}}, w[20:0]};
        exp_q.push_back(e);
        model_pc = model_pc + 5'd4;
        model_ret++;
      end
      6'h3E: begin
        model_pc = model_pc + 5'd4;
        model_ret++;
      end
      6'h3F: begin
        model_ret++;
        model_halted = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    if (model_halted) begin
      model_pc     = model_pc + 5'd4;
      model_halted = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Serve one fetch: ack after `delay` extra request cycles.
  task automatic fetch_one(input logic [31:0] w, input int delay,
                           output logic [4:0] addr, output int reqcnt);
    int guard;
    int unsigned ack_cyc;
    guard  = 0;
    reqcnt = 0;
    addr   = '0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (imem_req !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_wait: imem_req=0 after %0d cycles, expected request", guard);
      return;
    end
    addr   = imem_addr;
    reqcnt = 1;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) reqcnt++;
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    ack_cyc    = cyc;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    model_apply(w, ack_cyc);
  endtask

  task automatic wait_we(output logic [31:0] wd, output logic [4:0] wa,
                         output int unsigned at);
    bit seen;
    seen = 1'b0;
    wd   = '0;
    wa   = '0;
    at   = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        seen = 1'b1;
        wd   = rf_wd;
        wa   = rf_wa;
        at   = cyc;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_we: no rf_we within 10 cycles, expected a write");
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_rf_ra1"}, 32'(rf_ra1), 32'd0);
    chk({tag, "_rf_ra2"}, 32'(rf_ra2), 32'd0);
    chk({tag, "_rf_wa"}, 32'(rf_wa), 32'd0);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_rf_wd"}, rf_wd, 32'd0);
    chk({tag, "_alu_con"}, 32'(alu_con), 32'd0);
    chk({tag, "_alu_sft"}, 32'(alu_sft), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_pc     = '0;
    model_ret    = '0;
    model_halted = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  logic [4:0]  a;
  int          n;
  logic [31:0] wd;
  logic [4:0]  wa;
  int unsigned at;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    #2;
    rst = 1'b1;

    // R-type with immediate ack, then LI negative, then HALT at PC=8.
    pulse_start();
    fetch_one(rtype(5'd1, 5'd2, 5'd3, 5'd4, 3'd3), 0, a, n);
    chk("rtype_addr", 32'(a), 32'd0);
    wait_we(wd, wa, at);
    chk("rtype_wd", wd, 32'h10C8C2A5);
    chk("rtype_wa", 32'(wa), 32'd1);
    chk("rtype_latency", 32'(at - start_cyc), 32'd4);

    fetch_one(li(5'd4, 21'h1FFFFF), 0, a, n);
    chk("li_neg_addr", 32'(a), 32'd4);
    wait_we(wd, wa, at);
    chk("li_neg_wd", wd, 32'hFFFFFFFF);
    chk("li_neg_wa", 32'(wa), 32'd4);

    fetch_one(InsHalt, 0, a, n);
    chk("halt_addr", 32'(a), 32'd8);
    repeat (3) @(negedge clk);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(imem_addr), 32'd8);
    chk("halt_retired", 32'(retired), 32'd3);

    // Ack while halted must be ignored.
    @(posedge clk);
    #1;
    imem_ack   = 1'b1;
    imem_rdata = InsIll;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    @(negedge clk);
    chk("stray_ack_halted", 32'(halted), 32'd1);
    chk("stray_ack_fault", 32'(fault), 32'd0);
    chk("stray_ack_pc", 32'(imem_addr), 32'd8);

    // Restart from HALT resumes at PC+4.
    pulse_start();
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", 32'(imem_addr), 32'd12);
    fetch_one(li(5'd5, 21'h00005), 0, a, n);
    wait_we(wd, wa, at);
    chk("li_pos_wd", wd, 32'h00000005);
    fetch_one(InsNop, 0, a, n);
    chk("nop_addr", 32'(a), 32'd16);
    fetch_one(rtype(5'd7, 5'd9, 5'd10, 5'd31, 3'd7), 3, a, n);
    chk("delay3_reqcnt", 32'(n), 32'd4);
    chk("delay3_addr", 32'(a), 32'd20);
    chk("delay3_fault", 32'(fault), 32'd0);
    // Ack on the last allowed cycle is still accepted.
    fetch_one(rtype(5'd3, 5'd1, 5'd1, 5'd0, 3'd0), 14, a, n);
    chk("ackwin_reqcnt", 32'(n), 32'd15);
    chk("ackwin_fault", 32'(fault), 32'd0);
    fetch_one(li(5'd2, 21'h0ABCDE), 0, a, n);
    chk("pc28_addr", 32'(a), 32'd28);
    wait_we(wd, wa, at);
    chk("li_mid_wd", wd, 32'h000ABCDE);
    fetch_one(InsHalt, 0, a, n);
    chk("wrap_addr", 32'(a), 32'd0);
    repeat (2) @(negedge clk);
    chk("wrap_halted", 32'(halted), 32'd1);
    chk("wrap_retired", 32'(retired), 32'd9);
    chk("wrap_retired_model", 32'(retired), 32'(model_ret));

    // Fetch timeout: no ack ever arrives.
    pulse_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) n++;
      if (fault === 1'b1) break;
    end
    chk("timeout_reqcnt", 32'(n), 32'd15);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_req", 32'(imem_req), 32'd0);
    chk("timeout_pc", 32'(imem_addr), 32'd4);
    chk("timeout_retired", 32'(retired), 32'(model_ret));

    // Illegal opcode: sticky fault, start ignored.
    reset_dut();
    pulse_start();
    fetch_one(InsIll, 0, a, n);
    repeat (2) @(negedge clk);
    chk("illegal_fault", 32'(fault), 32'd1);
    chk("illegal_busy", 32'(busy), 32'd0);
    chk("illegal_retired", 32'(retired), 32'd0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_no_req", 32'(imem_req), 32'd0);
    chk("fault_pc", 32'(imem_addr), 32'd0);

    // Reset asserted during EXEC aborts the instruction.
    reset_dut();
    pulse_start();
    fetch_one(rtype(5'd1, 5'd2, 5'd3, 5'd4, 3'd3), 0, a, n);
    @(posedge clk);
    #1;
    chk("exec_alu_con", 32'(alu_con), 32'd3);
    chk("exec_alu_sft", 32'(alu_sft), 32'd4);
    chk("exec_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    model_clear();
    #1;
    chk_reset("exec_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_retired", 32'(retired), 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
